// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forwarding select codes and per-stage shadow info.
// Pure declarations; no logic, no latency, no flow control.
// Stall/freeze behaviour lives in hazard_ctrl.
package hazard_pkg;

   localparam int NUM_REGS = 32;
   localparam int REG_W    = $clog2(NUM_REGS);

   typedef logic [REG_W-1:0] reg_idx_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic     valid;
      reg_idx_t rs;
      reg_idx_t rt;
      reg_idx_t dest;
      logic     reg_write;
      logic     mem_to_reg;
      logic     mem_write;
   } stage_info_t;

   localparam stage_info_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding compare for one source register against the MEM and WB shadows.
// Purely combinational, zero latency; no flow control.
// MEM has priority over WB; register 0 never forwards.
module fwd_sel
   import hazard_pkg::*;
(
   input  logic       src_vld_i,
   input  reg_idx_t   src_i,
   input  logic       mem_vld_i,
   input  logic       mem_wr_i,
   input  reg_idx_t   mem_dest_i,
   input  logic       wb_vld_i,
   input  logic       wb_wr_i,
   input  reg_idx_t   wb_dest_i,
   output logic [1:0] sel_o
);

   always_comb begin
      sel_o = FWD_RF;
      if (src_vld_i && (src_i != '0)) begin
         if (mem_vld_i && mem_wr_i && (mem_dest_i == src_i)) begin
            sel_o = FWD_MEM;
         end else if (wb_vld_i && wb_wr_i && (wb_dest_i == src_i)) begin
            sel_o = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage MIPS hazard controller: shadows EX/MEM/WB write info, drives stall, flush and forwarding.
// Outputs are combinational from shadow state and current inputs; shadow updates on rising clk.
// mem_busy freezes everything; branch_taken_e beats load-use. HAZARD_STORE_FWD_EN enables load->store data forwarding.
module hazard_ctrl
   import hazard_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  rs_d,
   input  logic [4:0]  rt_d,
   input  logic        use_rs_d,
   input  logic        use_rt_d,
   input  logic [4:0]  dest_d,
   input  logic        reg_write_d,
   input  logic        mem_to_reg_d,
   input  logic        mem_write_d,
   input  logic        branch_taken_e,
   input  logic        mem_busy,
   output logic        stall_f,
   output logic        stall_d,
   output logic        stall_x,
   output logic        flush_d,
   output logic        flush_e,
   output logic [1:0]  fwd_a_e,
   output logic [1:0]  fwd_b_e,
   output logic        fwd_sw_m,
   output logic [15:0] stall_cnt
);

   stage_info_t ex_q, mem_q, wb_q;
   stage_info_t ex_d, id_info;
   logic [15:0] cnt_q, cnt_d;

   logic ex_is_load, rs_hit, rt_hit, store_exempt;
   logic load_use_raw, load_use, branch_flush;

   always_comb begin
      id_info            = STAGE_BUBBLE;
      id_info.valid      = 1'b1;
      id_info.rs         = rs_d;
      id_info.rt         = rt_d;
      id_info.dest       = dest_d;
      id_info.reg_write  = reg_write_d;
      id_info.mem_to_reg = mem_to_reg_d;
      id_info.mem_write  = mem_write_d;
   end

   assign ex_is_load = ex_q.valid && ex_q.reg_write && ex_q.mem_to_reg && (ex_q.dest != '0);
   assign rs_hit     = use_rs_d && (rs_d == ex_q.dest);
   assign rt_hit     = use_rt_d && (rt_d == ex_q.dest);

`ifdef HAZARD_STORE_FWD_EN
   // Store data can wait for the load to reach WB; only the address operand must stall.
   assign store_exempt = mem_write_d && rt_hit && !rs_hit;
`else
   assign store_exempt = 1'b0;
`endif

   assign load_use_raw = ex_is_load && (rs_hit || rt_hit) && !store_exempt;
   assign branch_flush = branch_taken_e && !mem_busy;
   assign load_use     = load_use_raw && !mem_busy && !branch_taken_e;

   assign stall_f   = mem_busy || load_use;
   assign stall_d   = mem_busy || load_use;
   assign stall_x   = mem_busy;
   assign flush_d   = branch_flush;
   assign flush_e   = branch_flush || load_use;
   assign stall_cnt = cnt_q;

   assign ex_d  = flush_e ? STAGE_BUBBLE : id_info;
   assign cnt_d = (load_use && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= STAGE_BUBBLE;
         mem_q <= STAGE_BUBBLE;
         wb_q  <= STAGE_BUBBLE;
         cnt_q <= '0;
      end else if (!mem_busy) begin
         ex_q  <= ex_d;
         mem_q <= ex_q;
         wb_q  <= mem_q;
         cnt_q <= cnt_d;
      end
   end

   fwd_sel u_fwd_a (
      .src_vld_i  (ex_q.valid),
      .src_i      (ex_q.rs),
      .mem_vld_i  (mem_q.valid),
      .mem_wr_i   (mem_q.reg_write),
      .mem_dest_i (mem_q.dest),
      .wb_vld_i   (wb_q.valid),
      .wb_wr_i    (wb_q.reg_write),
      .wb_dest_i  (wb_q.dest),
      .sel_o      (fwd_a_e)
   );

   fwd_sel u_fwd_b (
      .src_vld_i  (ex_q.valid),
      .src_i      (ex_q.rt),
      .mem_vld_i  (mem_q.valid),
      .mem_wr_i   (mem_q.reg_write),
      .mem_dest_i (mem_q.dest),
      .wb_vld_i   (wb_q.valid),
      .wb_wr_i    (wb_q.reg_write),
      .wb_dest_i  (wb_q.dest),
      .sel_o      (fwd_b_e)
   );

`ifdef HAZARD_STORE_FWD_EN
   logic [1:0] sw_sel;
   logic       wb_unused;

   // Reduced compare: only a load sitting in WB can feed the store in MEM.
   fwd_sel u_fwd_sw (
      .src_vld_i  (mem_q.valid && mem_q.mem_write),
      .src_i      (mem_q.rt),
      .mem_vld_i  (1'b0),
      .mem_wr_i   (1'b0),
      .mem_dest_i ('0),
      .wb_vld_i   (wb_q.valid),
      .wb_wr_i    (wb_q.reg_write && wb_q.mem_to_reg),
      .wb_dest_i  (wb_q.dest),
      .sel_o      (sw_sel)
   );

   assign fwd_sw_m  = (sw_sel == FWD_WB);
   assign wb_unused = ^{wb_q.rs, wb_q.rt, wb_q.mem_write};
`else
   logic wb_unused;

   assign fwd_sw_m  = 1'b0;
   assign wb_unused = ^{wb_q.rs, wb_q.rt, wb_q.mem_write, wb_q.mem_to_reg};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios with literal expectations, then random traffic
// checked every cycle against an instruction-level pipeline model.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  rs_d = '0, rt_d = '0, dest_d = '0;
   logic        use_rs_d = 1'b0, use_rt_d = 1'b0;
   logic        reg_write_d = 1'b0, mem_to_reg_d = 1'b0, mem_write_d = 1'b0;
   logic        branch_taken_e = 1'b0, mem_busy = 1'b0;
   logic        stall_f, stall_d, stall_x, flush_d, flush_e, fwd_sw_m;
   logic [1:0]  fwd_a_e, fwd_b_e;
   logic [15:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
      .dest_d(dest_d), .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d),
      .mem_write_d(mem_write_d), .branch_taken_e(branch_taken_e), .mem_busy(mem_busy),
      .stall_f(stall_f), .stall_d(stall_d), .stall_x(stall_x),
      .flush_d(flush_d), .flush_e(flush_e),
      .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_sw_m(fwd_sw_m),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- instruction-level reference model ----------------
   typedef struct {
      bit v;
      int rs, rt, dest;
      bit rw, ld, st;
   } ins_t;

   ins_t pipe[$];   // [0]=EX, [1]=MEM, [2]=WB
   int   m_cnt = 0;

   function automatic ins_t bubble();
      ins_t b;
      b.v = 0; b.rs = 0; b.rt = 0; b.dest = 0; b.rw = 0; b.ld = 0; b.st = 0;
      return b;
   endfunction

   function automatic int producer(int src);
      // Youngest older writer of src wins: MEM is checked before WB.
      if (!pipe[0].v || src == 0) return 0;
      if (pipe[1].v && pipe[1].rw && pipe[1].dest == src) return 2;
      if (pipe[2].v && pipe[2].rw && pipe[2].dest == src) return 1;
      return 0;
   endfunction

   initial begin
      for (int i = 0; i < 3; i++) pipe.push_back(bubble());
   end

   always @(negedge clk) begin
      bit hit, e_lu, e_br, e_sw;
      int e_fa, e_fb;
      ins_t n;
      if (!rst_n) begin
         pipe.delete();
         for (int i = 0; i < 3; i++) pipe.push_back(bubble());
         m_cnt = 0;
      end
      hit = pipe[0].v && pipe[0].rw && pipe[0].ld && pipe[0].dest != 0 &&
            ((use_rs_d && int'(rs_d) == pipe[0].dest) || (use_rt_d && int'(rt_d) == pipe[0].dest));
`ifdef HAZARD_STORE_FWD_EN
      if (mem_write_d && use_rt_d && int'(rt_d) == pipe[0].dest &&
          !(use_rs_d && int'(rs_d) == pipe[0].dest)) hit = 0;
      e_sw = pipe[1].v && pipe[1].st && pipe[2].v && pipe[2].rw && pipe[2].ld &&
             pipe[2].dest == pipe[1].rt && pipe[1].rt != 0;
`else
      e_sw = 0;
`endif
      e_br = branch_taken_e && !mem_busy;
      e_lu = hit && !mem_busy && !branch_taken_e;
      e_fa = producer(pipe[0].rs);
      e_fb = producer(pipe[0].rt);
      chk("m_stall_f", stall_f, mem_busy || e_lu);
      chk("m_stall_d", stall_d, mem_busy || e_lu);
      chk("m_stall_x", stall_x, mem_busy);
      chk("m_flush_d", flush_d, e_br);
      chk("m_flush_e", flush_e, e_br || e_lu);
      chk("m_fwd_a", fwd_a_e, e_fa);
      chk("m_fwd_b", fwd_b_e, e_fb);
      chk("m_fwd_sw", fwd_sw_m, e_sw);
      chk("m_cnt", stall_cnt, m_cnt);
      if (rst_n && !mem_busy) begin
         if (e_br || e_lu) n = bubble();
         else begin
            n.v = 1; n.rs = rs_d; n.rt = rt_d; n.dest = dest_d;
            n.rw = reg_write_d; n.ld = mem_to_reg_d; n.st = mem_write_d;
         end
         pipe.push_front(n);
         pipe.delete(3);
         if (e_lu && m_cnt < 65535) m_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic drv(input int rs, input int rt, input bit urs, input bit urt, input int dst,
                      input bit rw, input bit m2r, input bit mw, input bit br, input bit busy);
      @(posedge clk); #1;
      rs_d = 5'(rs); rt_d = 5'(rt); use_rs_d = urs; use_rt_d = urt; dest_d = 5'(dst);
      reg_write_d = rw; mem_to_reg_d = m2r; mem_write_d = mw;
      branch_taken_e = br; mem_busy = busy;
   endtask

   task automatic nop();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic probe();
      @(negedge clk); #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      probe();
      chk("rst_stall_d", stall_d, 0);
      chk("rst_cnt", stall_cnt, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // lw $5 ; add $6,$5,$7
      drv(1, 5, 1, 0, 5, 1, 1, 0, 0, 0); probe();
      chk("lu_no_stall_first", stall_d, 0);
      drv(5, 7, 1, 1, 6, 1, 0, 0, 0, 0); probe();
      chk("lu_stall_f", stall_f, 1);
      chk("lu_stall_d", stall_d, 1);
      chk("lu_flush_e", flush_e, 1);
      chk("lu_flush_d", flush_d, 0);
      drv(5, 7, 1, 1, 6, 1, 0, 0, 0, 0); probe();
      chk("lu_one_cycle", stall_d, 0);
      chk("lu_cnt", stall_cnt, 1);
      nop(); probe();
      chk("lu_fwd_a_wb", fwd_a_e, 1);
      chk("lu_fwd_b_rf", fwd_b_e, 0);
      repeat (3) nop();

      // add $3 ; sub $4,$3,$3
      drv(1, 2, 1, 1, 3, 1, 0, 0, 0, 0);
      drv(3, 3, 1, 1, 4, 1, 0, 0, 0, 0);
      nop(); probe();
      chk("alu_fwd_a_mem", fwd_a_e, 2);
      chk("alu_fwd_b_mem", fwd_b_e, 2);
      drv(1, 2, 1, 1, 3, 1, 0, 0, 0, 0);
      nop();
      drv(3, 3, 1, 1, 4, 1, 0, 0, 0, 0);
      nop(); probe();
      chk("alu_fwd_a_wb", fwd_a_e, 1);
      chk("alu_fwd_b_wb", fwd_b_e, 1);
      // load to $0 followed by a $0 reader: no stall, no forward
      drv(1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
      drv(0, 0, 1, 1, 4, 1, 0, 0, 0, 0); probe();
      chk("r0_no_stall", stall_d, 0);
      nop(); probe();
      chk("r0_fwd_a", fwd_a_e, 0);
      repeat (3) nop();

      // branch taken while a load-use is pending
      drv(1, 5, 1, 0, 5, 1, 1, 0, 0, 0);
      drv(5, 7, 1, 1, 6, 1, 0, 0, 1, 0); probe();
      chk("br_flush_d", flush_d, 1);
      chk("br_flush_e", flush_e, 1);
      chk("br_stall_d", stall_d, 0);
      nop(); probe();
      chk("br_cnt", stall_cnt, 1);
      repeat (3) nop();

      // mem_busy for 3 cycles over a load-use
      drv(1, 5, 1, 0, 5, 1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drv(5, 7, 1, 1, 6, 1, 0, 0, 0, 1); probe();
         chk("busy_stall_x", stall_x, 1);
         chk("busy_stall_d", stall_d, 1);
         chk("busy_flush_e", flush_e, 0);
      end
      drv(5, 7, 1, 1, 6, 1, 0, 0, 0, 0); probe();
      chk("busy_then_lu_x", stall_x, 0);
      chk("busy_then_lu_d", stall_d, 1);
      chk("busy_then_lu_fe", flush_e, 1);
      chk("busy_cnt_hold", stall_cnt, 1);
      drv(5, 7, 1, 1, 6, 1, 0, 0, 0, 0); probe();
      chk("busy_lu_done", stall_d, 0);
      chk("busy_cnt", stall_cnt, 2);
      repeat (3) nop();

      // lw $8 ; sw $8,0($9)
      drv(1, 8, 1, 0, 8, 1, 1, 0, 0, 0);
      drv(9, 8, 1, 1, 0, 0, 0, 1, 0, 0); probe();
`ifdef HAZARD_STORE_FWD_EN
      chk("sw_no_stall", stall_d, 0);
      nop();
      nop(); probe();
      chk("sw_fwd_m", fwd_sw_m, 1);
      chk("sw_cnt", stall_cnt, 2);
`else
      chk("sw_stall", stall_d, 1);
      drv(9, 8, 1, 1, 0, 0, 0, 1, 0, 0);
      nop(); probe();
      chk("sw_fwd_b_wb", fwd_b_e, 1);
      chk("sw_fwd_m_off", fwd_sw_m, 0);
      chk("sw_cnt", stall_cnt, 3);
`endif
      repeat (3) nop();

      // reset in the middle of a load-use stall
      drv(1, 5, 1, 0, 5, 1, 1, 0, 0, 0);
      drv(5, 7, 1, 1, 6, 1, 0, 0, 0, 0); probe();
      chk("rst_pre_stall", stall_d, 1);
      rst_n = 1'b0; #1;
      chk("rst_mid_stall_d", stall_d, 0);
      chk("rst_mid_flush_e", flush_e, 0);
      chk("rst_mid_cnt", stall_cnt, 0);
      rs_d = '0; rt_d = '0; use_rs_d = 0; use_rt_d = 0; dest_d = '0;
      reg_write_d = 0; mem_to_reg_d = 0; mem_write_d = 0;
      @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;

      // random traffic, small register range to provoke hazards
      for (int i = 0; i < 400; i++) begin
         drv($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      end
      nop();
      probe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
